// File: rtl/spi_master_ctrl.sv
// SPI register-access master: one valid/ready request becomes a 45-bit SID/WR/ADDR/DATA frame with optional 32-bit read capture.
// Acceptance to REQ_READY takes 92*CLK_DIV cycles; every output is registered and REQ_VALID is ignored while busy.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic [2:0]  REQ_SID,
  input  logic [6:0]  REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        BUSY,
  output logic        SPI_CLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_q, bit_d;
  logic [44:0]   frame_q, frame_d;
  logic [31:0]   rx_q, rx_d;
  logic          wr_q, wr_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          last;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    rx_d      = rx_q;
    wr_d      = wr_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    rsp_vld_d = 1'b0;
    rdata_d   = rdata_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    last      = (cnt_q == CNT_LAST);
    // One counter paces every phase: each state/half-period lasts CLK_DIV cycles.
    cnt_d     = last ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (REQ_VALID && ready_q) begin
          state_d = SETUP;
          wr_d    = REQ_WR;
          frame_d = {REQ_SID, REQ_WR, REQ_ADDR, (REQ_WR ? REQ_WDATA : 32'h0), 2'b00};
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
        end
      end
      SETUP: begin
        if (last) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          mosi_d  = frame_q[44];
          frame_d = {frame_q[43:0], 1'b0};
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (last) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            // MISO level just before the falling edge lands MSB first.
            if (bit_q >= 6'd11 && bit_q <= 6'd42) rx_d = {rx_q[30:0], SPI_MISO};
            if (bit_q == 6'd44) state_d = TAIL;
          end else begin
            sclk_d  = 1'b1;
            mosi_d  = frame_q[44];
            frame_d = {frame_q[43:0], 1'b0};
            bit_d   = bit_q + 6'd1;
          end
        end
      end
      TAIL: begin
        if (last) begin
          state_d   = GAP;
          cs_d      = 1'b1;
          rsp_vld_d = 1'b1;
          rdata_d   = wr_q ? 32'h0 : rx_q;
        end
      end
      GAP: begin
        if (last) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      rx_q      <= '0;
      wr_q      <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      rsp_vld_q <= 1'b0;
      rdata_q   <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      rx_q      <= rx_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      rsp_vld_q <= rsp_vld_d;
      rdata_q   <= rdata_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign REQ_READY = ready_q;
  assign BUSY      = busy_q;
  assign RSP_VALID = rsp_vld_q;
  assign RSP_RDATA = rdata_q;
  assign SPI_CLK   = sclk_q;
  assign SPI_CS    = cs_q;
  assign SPI_MOSI  = mosi_q;

endmodule
